// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MEMWAIT = 1'b1
   } hz_state_e;

   // Control bundle carried by ID/EX and later pipeline registers
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
   } pipe_ctrl_t;

   // A flushed stage carries this bundle: no register or memory side effects
   localparam pipe_ctrl_t NOP_CTRL = '0;

   // Load-use hazard between the instruction in ID and a load in ID/EX; x0 never hazards
   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic       uses_rs1,
      input logic [4:0] rs1,
      input logic       uses_rs2,
      input logic [4:0] rs2
   );
      return ex_mem_read && (ex_rd != 5'd0) &&
             ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: hold at all-ones instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, redirect flush, load-use stall.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             mem_access,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_bubble,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned          WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_e         state_q;
   logic              mem_err_q;
   logic [WAIT_W-1:0] wait_cnt;

   logic stall_enter;
   logic stall_hold;
   logic timeout_hit;
   logic freeze;
   logic redirect_fire;
   logic load_use;

   // Event decode in priority order: memory freeze, then redirect, then load-use.
   // The wait counter also counts the RUN cycle that enters MEMWAIT, so the abort
   // lands on the MEM_TIMEOUT-th frozen-or-aborting cycle of the access.
   always_comb begin
      stall_enter   = (state_q == ST_RUN) && mem_access && !dmem_ack;
      timeout_hit   = (state_q == ST_MEMWAIT) && !dmem_ack && (wait_cnt == WAIT_LAST);
      stall_hold    = (state_q == ST_MEMWAIT) && !dmem_ack && !timeout_hit;
      freeze        = stall_enter || stall_hold;
      redirect_fire = !freeze && ex_redirect;
      load_use      = !freeze && !ex_redirect &&
                      load_use_hazard(ex_mem_read, ex_rd, id_uses_rs1, id_rs1,
                                      id_uses_rs2, id_rs2);
   end

   // Mealy pipeline-register controls
   always_comb begin
      pc_en         = 1'b1;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_req      = mem_access && ((state_q == ST_RUN) || (state_q == ST_MEMWAIT));
      if (freeze) begin
         pc_en         = 1'b0;
         if_id_stall   = 1'b1;
         id_ex_stall   = 1'b1;
         ex_mem_stall  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else begin
         if (timeout_hit) begin
            mem_wb_bubble = 1'b1;
         end
         if (redirect_fire) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end
   end

   // Memory handshake FSM and sticky timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         mem_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (stall_enter) begin
                  state_q <= ST_MEMWAIT;
               end
            end
            ST_MEMWAIT: begin
               if (dmem_ack) begin
                  state_q <= ST_RUN;
               end else if (timeout_hit) begin
                  state_q   <= ST_RUN;
                  mem_err_q <= 1'b1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign mem_err = mem_err_q;

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk_i (clk),
      .clr_i (reset || !freeze),
      .inc_i (freeze),
      .cnt_o (wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk),
      .clr_i (reset),
      .inc_i (!pc_en),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk),
      .clr_i (reset),
      .inc_i (redirect_fire),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters for saturation).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
   logic          mem_access, dmem_ack;
   logic          pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic          ex_mem_stall, mem_wb_bubble, dmem_req, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, dmem_req}
   localparam logic [7:0] V_IDLE    = 8'b1000_0000;
   localparam logic [7:0] V_IDLE_RQ = 8'b1000_0001;
   localparam logic [7:0] V_FREEZE  = 8'b0101_0111;
   localparam logic [7:0] V_LOADUSE = 8'b0100_1000;
   localparam logic [7:0] V_REDIR   = 8'b1010_1000;
   localparam logic [7:0] V_REDIRRQ = 8'b1010_1001;
   localparam logic [7:0] V_TIMEOUT = 8'b1000_0011;

   logic [7:0] ctl;
   assign ctl = {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, mem_wb_bubble, dmem_req};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_redirect   (ex_redirect),
      .mem_access    (mem_access),
      .dmem_ack      (dmem_ack),
      .pc_en         (pc_en),
      .if_id_stall   (if_id_stall),
      .if_id_flush   (if_id_flush),
      .id_ex_stall   (id_ex_stall),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_stall  (ex_mem_stall),
      .mem_wb_bubble (mem_wb_bubble),
      .dmem_req      (dmem_req),
      .mem_err       (mem_err),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_redirect = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      settle();
      check("rst_ctl", 32'(ctl), 32'(V_IDLE));
      check("rst_stall_cnt", 32'(stall_cnt), 0);
      check("rst_flush_cnt", 32'(flush_cnt), 0);
      check("rst_mem_err", 32'(mem_err), 0);

      // Load-use on rs1, then on rs2
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
      settle();
      check("lu_rs1_ctl", 32'(ctl), 32'(V_LOADUSE));
      cyc();
      check("lu_rs1_cnt", 32'(stall_cnt), 1);
      id_uses_rs1 = 1'b0; id_rs1 = 5'd3; id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
      settle();
      check("lu_rs2_ctl", 32'(ctl), 32'(V_LOADUSE));
      cyc();
      check("lu_rs2_cnt", 32'(stall_cnt), 2);
      // x0 destination never hazards
      ex_rd = 5'd0; id_uses_rs1 = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
      settle();
      check("lu_x0_ctl", 32'(ctl), 32'(V_IDLE));
      // Address mismatch, and matching address that is not read
      ex_rd = 5'd5; id_rs1 = 5'd6; id_uses_rs2 = 1'b0; id_rs2 = 5'd5;
      settle();
      check("lu_nomatch_ctl", 32'(ctl), 32'(V_IDLE));
      cyc();
      check("lu_nomatch_cnt", 32'(stall_cnt), 2);

      // Redirect beats load-use
      id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_redirect = 1'b1;
      settle();
      check("redir_lu_ctl", 32'(ctl), 32'(V_REDIR));
      cyc();
      check("redir_flush_cnt", 32'(flush_cnt), 1);
      check("redir_stall_cnt", 32'(stall_cnt), 2);
      clear_inputs();

      // Zero-wait memory access
      mem_access = 1'b1; dmem_ack = 1'b1;
      settle();
      check("zw_ctl", 32'(ctl), 32'(V_IDLE_RQ));
      cyc();
      clear_inputs();
      settle();
      check("zw_after_ctl", 32'(ctl), 32'(V_IDLE));

      // Three-cycle wait; redirect during the wait is honoured only on release
      mem_access = 1'b1;
      settle();
      check("w3_c1", 32'(ctl), 32'(V_FREEZE));
      cyc();
      ex_redirect = 1'b1;
      settle();
      check("w3_c2", 32'(ctl), 32'(V_FREEZE));
      cyc();
      check("w3_c3", 32'(ctl), 32'(V_FREEZE));
      check("w3_c3_flush_cnt", 32'(flush_cnt), 1);
      cyc();
      dmem_ack = 1'b1;
      settle();
      check("w3_release", 32'(ctl), 32'(V_REDIRRQ));
      cyc();
      check("w3_stall_cnt", 32'(stall_cnt), 5);
      check("w3_flush_cnt", 32'(flush_cnt), 2);
      clear_inputs();
      settle();
      check("w3_after_ctl", 32'(ctl), 32'(V_IDLE));

      // Timeout: no ack, abort on the 4th cycle
      mem_access = 1'b1;
      settle();
      check("to_c1", 32'(ctl), 32'(V_FREEZE));
      cyc();
      check("to_c2", 32'(ctl), 32'(V_FREEZE));
      cyc();
      check("to_c3", 32'(ctl), 32'(V_FREEZE));
      cyc();
      check("to_c4", 32'(ctl), 32'(V_TIMEOUT));
      check("to_err_before", 32'(mem_err), 0);
      cyc();
      check("to_err", 32'(mem_err), 1);
      check("to_stall_cnt", 32'(stall_cnt), 8);
      mem_access = 1'b0;
      settle();
      check("to_after_ctl", 32'(ctl), 32'(V_IDLE));
      cyc(); cyc();
      check("to_err_sticky", 32'(mem_err), 1);

      // Reset while in MEMWAIT
      mem_access = 1'b1;
      settle();
      check("rw_enter", 32'(ctl), 32'(V_FREEZE));
      cyc();
      reset = 1'b1; mem_access = 1'b0;
      cyc();
      reset = 1'b0;
      settle();
      check("rw_ctl", 32'(ctl), 32'(V_IDLE));
      check("rw_stall_cnt", 32'(stall_cnt), 0);
      check("rw_flush_cnt", 32'(flush_cnt), 0);
      check("rw_mem_err", 32'(mem_err), 0);

      // Counter saturation
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_uses_rs2 = 1'b1; id_rs2 = 5'd7;
      for (int i = 0; i < 17; i++) cyc();
      check("sat_stall_cnt", 32'(stall_cnt), 15);
      clear_inputs();
      ex_redirect = 1'b1;
      for (int i = 0; i < 17; i++) cyc();
      check("sat_flush_cnt", 32'(flush_cnt), 15);
      check("sat_stall_hold", 32'(stall_cnt), 15);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
